// File: rtl/in_fifo_sync.sv
// in_fifo_sync: receive-side nibble-capture FIFO, packs nibble pairs to bytes, single clock RDCLK
//
// Ports:
//   RDCLK        clock for both write and read sides
//   RESET        asynchronous active-high reset
//   WREN, D      nibble write strobe and per-lane nibbles (lane n at D[4n+3:4n])
//   RDEN         pop request
//   Q            registered per-lane bytes (lane n at Q[8n+7:8n]), valid the cycle after the pop edge
//   EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL  flags decoded from the registered count
//   OVERFLOW, UNDERFLOW  sticky dropped-access flags, present only with `define IN_FIFO_ERR_FLAGS_EN
module in_fifo_sync #(
    parameter int NUM_LANES          = 10,
    parameter int DEPTH              = 8,
    parameter int ARRAY_MODE         = 1,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1
) (
    input  logic                   RDCLK,
    input  logic                   RESET,
    input  logic                   WREN,
    input  logic [4*NUM_LANES-1:0] D,
    input  logic                   RDEN,
    output logic [8*NUM_LANES-1:0] Q,
    output logic                   EMPTY,
    output logic                   ALMOSTEMPTY,
    output logic                   FULL,
    output logic                   ALMOSTFULL
`ifdef IN_FIFO_ERR_FLAGS_EN
    ,
    output logic                   OVERFLOW,
    output logic                   UNDERFLOW
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AE_TH  = CW'(ALMOST_EMPTY_VALUE);
    localparam logic [CW-1:0] AF_TH  = CW'(DEPTH - ALMOST_FULL_VALUE);
    localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

    if (DEPTH < 4 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > 2 ||
        ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > 2) begin : g_bad_param
        $fatal(1, "in_fifo_sync: illegal DEPTH or ALMOST_* parameter");
    end

    logic [8*NUM_LANES-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   phase_q, phase_d;
    logic [4*NUM_LANES-1:0] stage_q, stage_d;
    logic [8*NUM_LANES-1:0] q_q, q_d, wdata;
    logic                   wr_acc, rd_acc, push;

    // Accept decisions use the pre-edge flags: no write-through when full, no fall-through when empty.
    assign wr_acc = WREN && !FULL;
    assign rd_acc = RDEN && !EMPTY;
    assign push   = wr_acc && (ARRAY_MODE == 0 || phase_q);

    always_comb begin
        wdata = '0;
        for (int n = 0; n < NUM_LANES; n++)
            wdata[8*n +: 8] = (ARRAY_MODE != 0) ? {D[4*n +: 4], stage_q[4*n +: 4]} : {4'h0, D[4*n +: 4]};
    end

    always_comb begin
        phase_d  = (ARRAY_MODE != 0 && wr_acc) ? !phase_q : phase_q;
        stage_d  = (ARRAY_MODE != 0 && wr_acc && !phase_q) ? D : stage_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(rd_acc);
        q_d      = rd_acc ? mem[rd_ptr_q] : q_q;
    end

    always_ff @(posedge RDCLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            phase_q  <= 1'b0;
            stage_q  <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            stage_q  <= stage_d;
            q_q      <= q_d;
        end
    end

    // Storage needs no reset: RESET empties the FIFO by clearing pointers and count.
    always_ff @(posedge RDCLK) begin
        if (push)
            mem[wr_ptr_q] <= wdata;
    end

    assign Q           = q_q;
    assign EMPTY       = count_q == '0;
    assign ALMOSTEMPTY = count_q <= AE_TH;
    assign FULL        = count_q == FULL_N;
    assign ALMOSTFULL  = count_q >= AF_TH;

`ifdef IN_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q || (WREN && FULL);
        unf_d = unf_q || (RDEN && EMPTY);
    end

    always_ff @(posedge RDCLK or posedge RESET) begin
        if (RESET) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;
`endif
endmodule
